// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: programmable half period, all CPOL/CPHA modes,
// edge/sample/shift strobes and a bit counter with start/busy/done handshake.
module spi_sclk_gen #(
   parameter int DIV_W = 8,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cpol,
   input  logic             cpha,
   input  logic [DIV_W-1:0] div,
   input  logic [CNT_W-1:0] num_bits,
   output logic             sclk,
   output logic             leading_edge,
   output logic             trailing_edge,
   output logic             sample,
   output logic             shift,
   output logic [CNT_W-1:0] bit_idx,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_q, state_d;
   logic               sclk_q, sclk_d;
   logic               lead_q, lead_d;
   logic               trail_q, trail_d;
   logic               done_q, done_d;
   logic               arm_q, arm_d;
   logic               cpol_q, cpol_d;
   logic               cpha_q, cpha_d;
   logic [DIV_W-1:0]   hc_q, hc_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [CNT_W-1:0]   nb_q, nb_d;
   logic [CNT_W-1:0]   bit_q, bit_d;
   logic [CNT_W-1:0]   bit_nxt;

   assign bit_nxt = bit_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sclk_q  <= 1'b0;
         lead_q  <= 1'b0;
         trail_q <= 1'b0;
         done_q  <= 1'b0;
         arm_q   <= 1'b0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         hc_q    <= '0;
         div_q   <= '0;
         nb_q    <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         sclk_q  <= sclk_d;
         lead_q  <= lead_d;
         trail_q <= trail_d;
         done_q  <= done_d;
         arm_q   <= arm_d;
         cpol_q  <= cpol_d;
         cpha_q  <= cpha_d;
         hc_q    <= hc_d;
         div_q   <= div_d;
         nb_q    <= nb_d;
         bit_q   <= bit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sclk_d  = sclk_q;
      lead_d  = 1'b0;
      trail_d = 1'b0;
      done_d  = 1'b0;
      arm_d   = arm_q;
      cpol_d  = cpol_q;
      cpha_d  = cpha_q;
      hc_d    = hc_q;
      div_d   = div_q;
      nb_d    = nb_q;
      bit_d   = bit_q;
      unique case (state_q)
         IDLE: begin
            sclk_d = cpol;
            if (start && (num_bits != '0)) begin
               state_d = RUN;
               cpol_d  = cpol;
               cpha_d  = cpha;
               div_d   = div;
               nb_d    = num_bits;
               hc_d    = '0;
               bit_d   = '0;
               arm_d   = 1'b1;
            end
         end
         RUN: begin
            // One settling cycle after acceptance before the half-period count starts
            if (arm_q) begin
               arm_d = 1'b0;
            end else if (hc_q == div_q) begin
               hc_d   = '0;
               sclk_d = ~sclk_q;
               if (sclk_q == cpol_q) begin
                  lead_d = 1'b1;
               end else begin
                  trail_d = 1'b1;
                  bit_d   = bit_nxt;
                  if (bit_nxt == nb_q) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end
               end
            end else begin
               hc_d = hc_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign sclk          = sclk_q;
   assign leading_edge  = lead_q;
   assign trailing_edge = trail_q;
   assign sample        = cpha_q ? trail_q : lead_q;
   assign shift         = cpha_q ? lead_q : trail_q;
   assign bit_idx       = bit_q;
   assign busy          = (state_q == RUN);
   assign done          = done_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: edge-schedule model checked every cycle plus
// literal expectations for the directed bursts.
module tb_spi_sclk_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       cpol = 1'b0;
   logic       cpha = 1'b0;
   logic [7:0] div = '0;
   logic [4:0] num_bits = '0;
   logic       sclk, leading_edge, trailing_edge, sample, shift, busy, done;
   logic [4:0] bit_idx;

   spi_sclk_gen #(.DIV_W(8), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .cpol(cpol), .cpha(cpha),
      .div(div), .num_bits(num_bits), .sclk(sclk),
      .leading_edge(leading_edge), .trailing_edge(trailing_edge),
      .sample(sample), .shift(shift), .bit_idx(bit_idx),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad < 40) $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   // Model: a burst accepted at edge k with half period D=div+1 and N bits
   // has its n-th edge at edge k+1+D*n, n=1..2N; the last edge ends it.
   bit   have = 0;
   int   k_s, end_s, dv, nb, t, m, n;
   bit   cp_l, ch_l;
   logic e_sclk, e_lead, e_trail, e_done, e_busy;
   logic [4:0] e_bit;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         have = 0; e_sclk = 0; e_lead = 0; e_trail = 0; e_done = 0;
         e_busy = 0; e_bit = 0; ch_l = 0;
      end else begin
         if (!(have && cyc <= end_s) && start && num_bits != 0) begin
            have = 1; k_s = cyc; dv = int'(div) + 1; nb = int'(num_bits);
            cp_l = cpol; ch_l = cpha; end_s = k_s + 1 + dv * 2 * nb;
         end
         e_lead = 0; e_trail = 0; e_done = 0;
         if (have && cyc <= end_s) begin
            t = cyc - k_s - 1;
            m = (t < 0) ? 0 : t / dv;
            e_sclk = cp_l ^ m[0];
            e_bit  = 5'(m / 2);
            e_busy = (cyc < end_s);
            if (t > 0 && (t % dv) == 0) begin
               n = t / dv;
               e_lead  = n[0];
               e_trail = !n[0];
               e_done  = (n == 2 * nb);
            end
         end else begin
            e_sclk = cpol;
            e_busy = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("sclk", 32'(sclk), 32'(e_sclk));
         chk("leading_edge", 32'(leading_edge), 32'(e_lead));
         chk("trailing_edge", 32'(trailing_edge), 32'(e_trail));
         chk("sample", 32'(sample), 32'(ch_l ? e_trail : e_lead));
         chk("shift", 32'(shift), 32'(ch_l ? e_lead : e_trail));
         chk("bit_idx", 32'(bit_idx), 32'(e_bit));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("done", 32'(done), 32'(e_done));
      end
   end

   task automatic go(input bit p, input bit h, input int d, input int nbits, output int k);
      cpol = p; cpha = h; div = d[7:0]; num_bits = nbits[4:0]; start = 1'b1;
      @(negedge clk);
      k = cyc;
      start = 1'b0;
   endtask

   task automatic at(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   int k;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_sclk", 32'(sclk), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_bit_idx", 32'(bit_idx), 0);
      chk("rst_done", 32'(done), 0);
      rst = 1'b0;
      @(negedge clk);

      // Mode 0, div=1, 8 bits
      go(0, 0, 1, 8, k);
      at(k + 3);
      chk("m0_lead1", 32'(leading_edge), 1);
      chk("m0_sclk_hi", 32'(sclk), 1);
      chk("m0_sample1", 32'(sample), 1);
      at(k + 5);
      chk("m0_trail1", 32'(trailing_edge), 1);
      chk("m0_shift1", 32'(shift), 1);
      at(k + 32);
      chk("m0_busy_late", 32'(busy), 1);
      at(k + 33);
      chk("m0_done", 32'(done), 1);
      chk("m0_busy_end", 32'(busy), 0);
      chk("m0_bits", 32'(bit_idx), 8);
      repeat (3) @(negedge clk);

      // Mode 3, div=0, 1 bit
      cpol = 1'b1;
      repeat (2) @(negedge clk);
      go(1, 1, 0, 1, k);
      at(k + 2);
      chk("m3_lead", 32'(leading_edge), 1);
      chk("m3_shift", 32'(shift), 1);
      chk("m3_sclk_lo", 32'(sclk), 0);
      at(k + 3);
      chk("m3_sample", 32'(sample), 1);
      chk("m3_done", 32'(done), 1);
      chk("m3_sclk_hi", 32'(sclk), 1);
      chk("m3_busy", 32'(busy), 0);
      repeat (3) @(negedge clk);

      // Mode 1 then mode 2, div=2, 2 bits
      go(0, 1, 2, 2, k);
      at(k + 4);
      chk("m1_lead", 32'(leading_edge), 1);
      chk("m1_sample_lead", 32'(sample), 0);
      at(k + 7);
      chk("m1_sample_trail", 32'(sample), 1);
      at(k + 13);
      chk("m1_done", 32'(done), 1);
      cpol = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_follows_cpol", 32'(sclk), 1);
      go(1, 0, 2, 2, k);
      at(k + 4);
      chk("m2_sample_lead", 32'(sample), 1);
      chk("m2_sclk_lo", 32'(sclk), 0);
      repeat (12) @(negedge clk);

      // Start while busy, div change mid-burst, zero-length request
      go(0, 0, 1, 4, k);
      at(k + 6);
      div = 8'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      at(k + 16);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_start_done", 32'(done), 1);
      at(k + 20);
      chk("busy_start_ignored", 32'(busy), 0);
      go(0, 0, 1, 0, k);
      repeat (3) @(negedge clk);
      chk("zero_bits_ignored", 32'(busy), 0);

      // Reset after the third edge of an 8-bit burst
      go(0, 0, 1, 8, k);
      at(k + 7);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_sclk", 32'(sclk), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_bit_idx", 32'(bit_idx), 0);
      chk("abort_done", 32'(done), 0);
      go(1, 1, 3, 8, k);
      at(k + 65);
      chk("after_abort_done", 32'(done), 1);
      chk("after_abort_bits", 32'(bit_idx), 8);
      repeat (3) @(negedge clk);

      // Maximum divisor
      go(0, 0, 255, 1, k);
      at(k + 256);
      chk("maxdiv_no_early", 32'(leading_edge), 0);
      at(k + 257);
      chk("maxdiv_lead", 32'(leading_edge), 1);
      chk("maxdiv_sclk", 32'(sclk), 1);
      at(k + 513);
      chk("maxdiv_done", 32'(done), 1);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
